// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and receiver FSM encoding.
package vga_pkg;

    localparam int unsigned H_SYNC  = 96;
    localparam int unsigned H_BACK  = 40;
    localparam int unsigned H_LEFT  = 8;
    localparam int unsigned H_VALID = 640;
    localparam int unsigned H_RIGHT = 8;
    localparam int unsigned H_FRONT = 8;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;

    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BACK   = 25;
    localparam int unsigned V_TOP    = 8;
    localparam int unsigned V_VALID  = 480;
    localparam int unsigned V_BOTTOM = 8;
    localparam int unsigned V_FRONT  = 2;
    localparam int unsigned V_TOTAL  = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;

    localparam int unsigned H_ACT_START = H_SYNC + H_BACK + H_LEFT;
    localparam int unsigned H_ACT_END   = H_ACT_START + H_VALID - 1;
    localparam int unsigned V_ACT_START = V_SYNC + V_BACK + V_TOP;
    localparam int unsigned V_ACT_END   = V_ACT_START + V_VALID - 1;

    localparam int unsigned POS_W = 10;
    localparam logic [POS_W-1:0] POS_MAX    = '1;
    localparam logic [POS_W-1:0] POS_MAX_M1 = POS_MAX - 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_LOCKED = 2'd2
    } vga_state_t;

    // Increment that sticks at the all-ones value.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (v == POS_MAX) ? v : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers the sync inputs once and flags their rising edges.
module vga_edge_det (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic hsync,
    input  logic vsync,
    output logic hs_rise,
    output logic vs_rise
);

    logic hs_q, vs_q, hs_d, vs_d;

    // input capture plus one-sample history for edge detection
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            hs_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            hs_q <= hsync;
            vs_q <= vsync;
            hs_d <= hs_q;
            vs_d <= vs_q;
        end
    end

    assign hs_rise = hs_q & ~hs_d;
    assign vs_rise = vs_q & ~vs_d;

endmodule

// File: rtl/vga_rx.sv
// VGA receiver: tracks sync timing, locks after a clean frame, emits pixels.
module vga_rx
    import vga_pkg::*;
#(
    parameter int unsigned LINE_LEN  = H_TOTAL,
    parameter int unsigned FRAME_LEN = V_TOTAL,
    parameter int unsigned H_ACT_LO  = H_ACT_START,
    parameter int unsigned H_ACT_HI  = H_ACT_END,
    parameter int unsigned V_ACT_LO  = V_ACT_START,
    parameter int unsigned V_ACT_HI  = V_ACT_END
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [15:0] rgb,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err
);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(LINE_LEN - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0] H_LO   = POS_W'(H_ACT_LO);
    localparam logic [POS_W-1:0] H_HI   = POS_W'(H_ACT_HI);
    localparam logic [POS_W-1:0] V_LO   = POS_W'(V_ACT_LO);
    localparam logic [POS_W-1:0] V_HI   = POS_W'(V_ACT_HI);

    logic             hs_rise, vs_rise;
    logic [15:0]      rgb_q;
    logic [POS_W-1:0] h_pos, v_pos, h_cur, v_cur;
    logic             vs_pend;
    logic             viol, in_win, lock_nxt;
    logic             frame_ok, frame_ok_nxt;
    vga_state_t       state, state_nxt;

    vga_edge_det u_edge (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .hsync     (hsync),
        .vsync     (vsync),
        .hs_rise   (hs_rise),
        .vs_rise   (vs_rise)
    );

    // pixel capture aligned with the registered sync copies
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) rgb_q <= '0;
        else            rgb_q <= rgb;
    end

    // position of the sample now held in rgb_q; vsync zeroes the row at the next line start
    always_comb begin
        h_cur = hs_rise ? '0 : sat_inc(h_pos);
        v_cur = v_pos;
        if (hs_rise) v_cur = (vs_rise || vs_pend) ? '0 : sat_inc(v_pos);
    end

    // position counters and the vsync-seen-but-line-not-yet-started flag
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_pos   <= '0;
            v_pos   <= '0;
            vs_pend <= 1'b0;
        end else begin
            h_pos   <= h_cur;
            v_pos   <= v_cur;
            vs_pend <= hs_rise ? 1'b0 : (vs_pend | vs_rise);
        end
    end

    // timing checks against the previous sample's position, plus window decode
    always_comb begin
        viol = 1'b0;
        if (hs_rise && h_pos != H_LAST)       viol = 1'b1;
        if (vs_rise && v_pos != V_LAST)       viol = 1'b1;
        if (!hs_rise && h_pos == POS_MAX_M1)  viol = 1'b1;
        in_win = (h_cur >= H_LO) && (h_cur <= H_HI) && (v_cur >= V_LO) && (v_cur <= V_HI);
    end

    // FSM state and clean-frame flag registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            frame_ok <= 1'b0;
        end else begin
            state    <= state_nxt;
            frame_ok <= frame_ok_nxt;
        end
    end

    // FSM next state; a vsync always opens a fresh candidate frame
    always_comb begin
        state_nxt    = state;
        frame_ok_nxt = frame_ok;
        unique case (state)
            ST_IDLE: begin
                if (vs_rise) begin
                    state_nxt    = ST_ALIGN;
                    frame_ok_nxt = 1'b1;
                end
            end
            ST_ALIGN: begin
                if (viol) begin
                    frame_ok_nxt = vs_rise;
                end else if (vs_rise) begin
                    if (frame_ok) state_nxt = ST_LOCKED;
                    frame_ok_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (viol) begin
                    state_nxt    = ST_ALIGN;
                    frame_ok_nxt = vs_rise;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        lock_nxt = (state_nxt == ST_LOCKED);
    end

    // output registers, two samples behind the input pins
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
        end else begin
            pix_valid   <= lock_nxt && in_win;
            frame_start <= lock_nxt && in_win && (h_cur == H_LO) && (v_cur == V_LO);
            locked      <= lock_nxt;
            err         <= viol && (state != ST_IDLE);
            if (lock_nxt && in_win) begin
                pix_x    <= h_cur - H_LO;
                pix_y    <= v_cur - V_LO;
                pix_data <= rgb_q;
            end
        end
    end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 SHALL have port: sys_clk  input  1  pixel clock (25 MHz nominal), same clock domain as the source.
REQ-002 SHALL have port: sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: hsync  input  1  line sync, active-high.
REQ-004 SHALL have port: vsync  input  1  frame sync, active-high.
REQ-005 SHALL have port: rgb  input  16  RGB565 pixel sample.
REQ-006 SHALL have port: pix_x  output  10  column of the current valid pixel, 0..639.
REQ-007 SHALL have port: pix_y  output  10  row of the current valid pixel, 0..479.
REQ-008 SHALL have port: pix_data  output  16  captured RGB565 pixel.
REQ-009 SHALL have port: pix_valid  output  1  pix_x, pix_y and pix_data are valid this cycle.
REQ-010 SHALL have port: frame_start  output  1  one-cycle pulse with the pixel at (0,0).
REQ-011 SHALL have port: locked  output  1  timing verified; pixel output enabled.
REQ-012 SHALL have port: err  output  1  one-cycle pulse on a timing violation.

Function
REQ-013 SHALL use timing 640x480@60: H_TOTAL 800 (sync 96, back 40, left 8, valid 640, right 8, front 8); V_TOTAL 525 (sync 2, back 25, top 8, valid 480, bottom 8, front 2).
REQ-014 SHALL register hsync, vsync and rgb once, then edge-detect on the registered copies.
REQ-015 SHALL give h_pos = 0 to the first sample with hsync high, then increment h_pos per sample; h_pos SHALL saturate at 1023.
REQ-016 SHALL set v_pos to 0 at an hsync rising edge coincident with, or first following, a vsync rising edge; every other hsync rising edge SHALL increment v_pos, saturating at 1023.
REQ-017 SHALL define the active window as h_pos 144..783 and v_pos 35..514, with pix_x = h_pos-144 and pix_y = v_pos-35.
REQ-018 SHALL assert pix_valid only inside the active window while locked=1.
REQ-019 SHALL present all outputs registered, exactly 2 cycles after the corresponding rgb sample is at the input.
REQ-020 SHALL implement a 3-state FSM with states IDLE, ALIGN and LOCKED.
REQ-021 FSM IDLE: go to ALIGN on the first vsync rising edge.
REQ-022 FSM ALIGN: go to LOCKED on the next vsync rising edge, provided that every line in the frame was exactly 800 samples and the frame was exactly 525 lines.
REQ-023 FSM LOCKED: locked=1.
REQ-024 SHALL treat as a violation: an hsync edge with h_pos != 799; a vsync edge with v_pos != 524 (the first edge in IDLE is exempt); h_pos reaching 1023.
REQ-025 On a violation in ALIGN or LOCKED, SHALL pulse err for 1 cycle, return to ALIGN and deassert locked in the same cycle; counters SHALL then resync per REQ-015/016.
REQ-026 SHALL pulse frame_start together with pix_valid at pix_x=0, pix_y=0.
REQ-027 Outside valid cycles, pix_data SHALL hold its last value.

Reset
REQ-028 On sys_rst_n=0, SHALL asynchronously clear the input registers, h_pos, v_pos, pix_x, pix_y, pix_data, pix_valid, frame_start, locked and err to 0, and set the FSM to IDLE.
REQ-029 A reset mid-frame SHALL require a full ALIGN frame before locked rises again.

Structure
REQ-030 Timing constants (H_*, V_*, active bounds) and the FSM state encoding SHALL reside in shared package vga_pkg, also used by vga_ctrl.
REQ-031 SHALL instantiate one sub-module, vga_edge_det, for the register and rising-edge detection of hsync and vsync.

Verification
REQ-032 Loopback: vga_ctrl -> vga_rx with pix_data=16'hFFFF -> locked rises at the start of the 2nd vsync; the next frame gives exactly 307200 pix_valid cycles, all with data FFFF.
REQ-033 Coordinate pattern: source rgb = {pix_x[5:0], pix_y[9:0]} -> each captured pix_data matches its pix_x/pix_y; frame_start count = 1 per frame.
REQ-034 Short line: one line of 799 samples while locked -> 1 err pulse, locked=0, re-lock after one clean frame.
REQ-035 hsync held low for 1100 cycles -> h_pos saturates, err pulse, no pix_valid.
REQ-036 sys_rst_n asserted for 3 cycles at pixel (320,240) -> all outputs 0 immediately; locked returns only after 2 further vsync edges.
REQ-037 vsync rising 5 samples after an hsync edge -> v_pos is zeroed at the next hsync edge and pix_y=0 falls on line 35 after it.
